// File: rtl/uart_rx_ip.sv
// Memory-mapped 8N1 UART receiver with a small RX FIFO; one-cycle registered read data.
// A byte arriving while the FIFO is full (and not popped that cycle) is dropped and flags overrun.
module uart_rx_ip #(
  parameter int clk_freq_hz = 12_000_000,
  parameter int baud_rate   = 9600,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rxd,
  input  logic        i_sel,
  input  logic        i_rstrb,
  input  logic        i_we,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_rx_avail
);

  localparam int DIV  = clk_freq_hz / baud_rate;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int PW   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic          rx_meta_q, rxs_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bidx_q;
  logic [7:0]    shift_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [3:0]    count_q;
  logic          ovr_q, ferr_q;
  logic [31:0]   rdata_q;

  logic cnt_zero, push, ferr_set;
  logic rd_en, wr_status, empty, full, pop, push_ok, ovr_set;
  logic [31:0] status_word;
  logic unused_bits;

  assign unused_bits = ^{i_addr[3], i_addr[1:0], i_wdata[31:3], i_wdata[0]};

  // Sync flops reset high so a reset never looks like a start bit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= i_rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  assign cnt_zero = (cnt_q == '0);
  assign push     = (state_q == S_STOP) && cnt_zero && rxs_q;
  assign ferr_set = (state_q == S_STOP) && cnt_zero && !rxs_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_q <= S_START;
            cnt_q   <= CW'(HALF - 1);
          end
        end
        S_START: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!rxs_q) begin
            state_q <= S_DATA;
            cnt_q   <= CW'(DIV - 1);
            bidx_q  <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DATA: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q <= {rxs_q, shift_q[7:1]};
            cnt_q   <= CW'(DIV - 1);
            if (bidx_q == 3'd7) state_q <= S_STOP;
            else                bidx_q  <= bidx_q + 1'b1;
          end
        end
        S_STOP: begin
          if (!cnt_zero) cnt_q   <= cnt_q - 1'b1;
          else           state_q <= rxs_q ? S_IDLE : S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (rxs_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_en     = i_sel & i_rstrb;
  assign wr_status = i_sel & i_we & i_addr[2];
  assign empty     = (count_q == 4'd0);
  assign full      = (count_q == 4'(FIFO_DEPTH));
  assign pop       = rd_en & ~i_addr[2] & ~empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign push_ok   = push & (~full | pop);
  assign ovr_set   = push & full & ~pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wptr_q] <= shift_q;
  end

  // Sticky flags: a new error in the same cycle as a W1C clear wins
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set  | (ovr_q  & ~(wr_status & i_wdata[1]));
      ferr_q <= ferr_set | (ferr_q & ~(wr_status & i_wdata[2]));
    end
  end

  assign status_word = {24'b0, count_q, 1'b0, ferr_q, ovr_q, ~empty};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      if (i_addr[2])  rdata_q <= status_word;
      else if (empty) rdata_q <= '0;
      else            rdata_q <= {24'b0, mem_q[rptr_q]};
    end
  end

  assign o_rdata    = rdata_q;
  assign o_rx_avail = ~empty;

endmodule

// File: tb/tb_uart_rx_ip.sv
// Directed bench for uart_rx_ip: serial frames in, bus reads checked against a queue model.
module tb_uart_rx_ip;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_rxd = 1'b1;
  logic        i_sel = 1'b0;
  logic        i_rstrb = 1'b0;
  logic        i_we = 1'b0;
  logic [3:0]  i_addr = 4'h0;
  logic [31:0] i_wdata = 32'h0;
  logic [31:0] o_rdata;
  logic        o_rx_avail;

  uart_rx_ip #(.clk_freq_hz(16), .baud_rate(1), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rxd(i_rxd), .i_sel(i_sel), .i_rstrb(i_rstrb),
    .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_rx_avail(o_rx_avail)
  );

  always #5 i_clk = ~i_clk;

  // Model: received bytes waiting for firmware, plus the two sticky flags
  byte unsigned mq[$];
  bit           m_ovr = 1'b0;
  bit           m_ferr = 1'b0;

  int          n_total = 0;
  int          n_pass = 0;
  bit          stable = 1'b0;
  bit          rd_pend = 1'b0;
  bit          rd_lit_en = 1'b0;
  logic [31:0] rd_exp = 32'h0;
  logic [31:0] rd_lit = 32'h0;
  string       rd_name = "";

  function automatic logic [31:0] model_status();
    logic [3:0] cnt;
    cnt = 4'(mq.size());
    return {24'b0, cnt, 1'b0, m_ferr, m_ovr, (mq.size() != 0)};
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)                m_ferr = 1'b1;
    else if (mq.size() == DEPTH) m_ovr  = 1'b1;
    else                         mq.push_back(b);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  always @(negedge i_clk) begin
    if (rd_pend) begin
      chk(rd_name, o_rdata, rd_exp);
      if (rd_lit_en) chk({rd_name, "_lit"}, o_rdata, rd_lit);
    end else if (stable) begin
      chk("rdata_hold", o_rdata, rd_exp);
    end
    if (stable) chk("avail", {31'b0, o_rx_avail}, {31'b0, (mq.size() != 0)});
  end

  task automatic bus_read(input string name, input logic [3:0] addr,
                          input bit lit_en, input logic [31:0] lit);
    @(negedge i_clk); #1;
    i_sel = 1'b1; i_rstrb = 1'b1; i_addr = addr;
    if (addr[2])             rd_exp = model_status();
    else if (mq.size() != 0) rd_exp = {24'b0, mq.pop_front()};
    else                     rd_exp = 32'h0;
    rd_name = name; rd_lit_en = lit_en; rd_lit = lit;
    @(posedge i_clk); #1;
    i_sel = 1'b0; i_rstrb = 1'b0; rd_pend = 1'b1;
    @(negedge i_clk); #1;
    rd_pend = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge i_clk); #1;
    i_sel = 1'b1; i_we = 1'b1; i_addr = addr; i_wdata = data;
    @(posedge i_clk); #1;
    i_sel = 1'b0; i_we = 1'b0; i_wdata = 32'h0;
    if (addr[2]) begin
      if (data[1]) m_ovr  = 1'b0;
      if (data[2]) m_ferr = 1'b0;
    end
  endtask

  task automatic do_reset();
    stable = 1'b0;
    @(negedge i_clk); #1;
    i_rst = 1'b1; i_rxd = 1'b1;
    @(negedge i_clk); #1;
    i_rst = 1'b0;
    mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0; rd_exp = 32'h0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int stop_cyc);
    stable = 1'b0;
    @(negedge i_clk);
    i_rxd = 1'b0;
    repeat (DIV) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rxd = b[i];
      repeat (DIV) @(negedge i_clk);
    end
    i_rxd = stop_hi;
    repeat (stop_cyc) @(negedge i_clk);
    i_rxd = 1'b1;
    repeat (DIV) @(negedge i_clk);
    model_frame(b, stop_hi);
    stable = 1'b1;
  endtask

  initial begin
    logic [7:0] seq [4];
    logic [7:0] part;
    seq[0] = 8'hA3; seq[1] = 8'h0F; seq[2] = 8'hFF; seq[3] = 8'h00;

    repeat (3) @(negedge i_clk);
    do_reset();
    repeat (4) @(negedge i_clk);
    stable = 1'b1;
    bus_read("rst_status", 4'h4, 1'b1, 32'h00);
    bus_read("rst_data_empty", 4'h0, 1'b1, 32'h00);

    // Single frame
    send_frame(8'h55, 1'b1, DIV);
    bus_read("s1_status", 4'h4, 1'b1, 32'h11);
    bus_read("s1_data", 4'h0, 1'b1, 32'h55);
    bus_read("s1_status2", 4'h4, 1'b1, 32'h00);

    // Fill the FIFO and drain in order
    for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b1, DIV);
    bus_read("s2_status", 4'h4, 1'b1, 32'h41);
    for (int i = 0; i < 4; i++) bus_read("s2_data", 4'h0, 1'b1, {24'b0, seq[i]});

    // Overrun on a fifth byte
    for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b1, DIV);
    send_frame(8'h7E, 1'b1, DIV);
    bus_read("s3_status", 4'h4, 1'b1, 32'h43);
    bus_write(4'h0, 32'h6);
    bus_read("s3_status_dwr", 4'h4, 1'b1, 32'h43);
    for (int i = 0; i < 4; i++) bus_read("s3_data", 4'h0, 1'b1, {24'b0, seq[i]});
    bus_read("s3_data_empty", 4'h0, 1'b1, 32'h00);
    bus_read("s3_status_ovr", 4'h4, 1'b1, 32'h02);
    bus_write(4'h4, 32'h2);
    bus_read("s3_status_clr", 4'h4, 1'b1, 32'h00);

    // Framing error with line held low, then a good frame
    send_frame(8'h5A, 1'b0, 40);
    bus_read("s4_status_ferr", 4'h4, 1'b1, 32'h04);
    send_frame(8'h12, 1'b1, DIV);
    bus_read("s4_status", 4'h4, 1'b1, 32'h15);
    bus_read("s4_data", 4'h0, 1'b1, 32'h12);
    bus_write(4'h4, 32'h4);
    bus_read("s4_status_clr", 4'h4, 1'b1, 32'h00);

    // Short low glitch is rejected
    @(negedge i_clk);
    i_rxd = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rxd = 1'b1;
    repeat (30) @(negedge i_clk);
    bus_read("s5_status", 4'h4, 1'b1, 32'h00);

    // Reset mid-frame flushes a queued byte and aborts the frame
    send_frame(8'h99, 1'b1, DIV);
    part = 8'hC3;
    stable = 1'b0;
    @(negedge i_clk);
    i_rxd = 1'b0;
    repeat (DIV) @(negedge i_clk);
    for (int i = 0; i < 3; i++) begin
      i_rxd = part[i];
      repeat (DIV) @(negedge i_clk);
    end
    i_rxd = part[3];
    repeat (DIV / 2) @(negedge i_clk);
    do_reset();
    repeat (40) @(negedge i_clk);
    stable = 1'b1;
    bus_read("s6_status_rst", 4'h4, 1'b1, 32'h00);
    send_frame(8'h3C, 1'b1, DIV);
    bus_read("s6_data", 4'h0, 1'b1, 32'h3C);
    bus_read("s6_status", 4'h4, 1'b1, 32'h00);

    repeat (4) @(negedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
